// File: rtl/chart_pkg.sv
// Shared chart-word layout, judgement encodings and default timing/score constants
// for the rhythm-game lane logic.
package chart_pkg;

   localparam int NOTE_W  = 16;
   localparam int TIME_W  = 14;
   localparam int TYPE_HI = 15;
   localparam int TYPE_LO = 14;
   localparam int TIME_HI = 13;
   localparam int TIME_LO = 0;

   localparam int DEF_NOTE_COUNT  = 128;
   localparam int DEF_PERFECT_WIN = 3;
   localparam int DEF_GOOD_WIN    = 6;
   localparam int DEF_PERFECT_PTS = 100;
   localparam int DEF_GOOD_PTS    = 50;

   typedef enum logic [1:0] {
      NOTE_TAP    = 2'b00,
      NOTE_HOLD_S = 2'b01,
      NOTE_HOLD_E = 2'b10,
      NOTE_RSVD   = 2'b11
   } note_type_e;

   typedef enum logic [1:0] {
      J_MISS    = 2'b00,
      J_GOOD    = 2'b01,
      J_PERFECT = 2'b10
   } judge_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_HOLD,
      S_DONE
   } lane_state_e;

   // Widened by one bit so early notes give a negative offset instead of wrapping.
   function automatic logic signed [TIME_W:0] note_dt(input logic [TIME_W-1:0] now,
                                                      input logic [TIME_W-1:0] noteTime);
      return $signed({1'b0, now}) - $signed({1'b0, noteTime});
   endfunction

   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

endpackage

// File: rtl/key_edge.sv
// Two-flop synchroniser for a raw key level plus one-cycle press/release pulses
// taken from the synchronised signal.
module key_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic key_i,
   output logic press_o,
   output logic release_o
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= key_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign press_o   = sync2_q & ~prev_q;
   assign release_o = ~sync2_q & prev_q;

endmodule

// File: rtl/lane_judge.sv
// Per-lane chart sequencer: walks the lane's chart ROM, grades key presses and hold
// releases against the song clock, and keeps the lane's combo and score.
module lane_judge
   import chart_pkg::*;
#(
   parameter int unsigned NOTE_COUNT  = DEF_NOTE_COUNT,
   parameter int unsigned PERFECT_WIN = DEF_PERFECT_WIN,
   parameter int unsigned GOOD_WIN    = DEF_GOOD_WIN,
   parameter int unsigned PERFECT_PTS = DEF_PERFECT_PTS,
   parameter int unsigned GOOD_PTS    = DEF_GOOD_PTS
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        start,
   input  logic [13:0] song_time,
   input  logic        key_in,
   input  logic [15:0] key_1,
   input  logic [15:0] key_2,
   output logic [7:0]  addr,
   output logic        judge_valid,
   output logic [1:0]  judge_code,
   output logic [9:0]  combo,
   output logic [15:0] score,
   output logic        holding,
   output logic        done
);

   localparam logic signed [TIME_W:0] GOOD_S = (TIME_W+1)'(GOOD_WIN);
   localparam logic signed [TIME_W:0] PERF_S = (TIME_W+1)'(PERFECT_WIN);
   localparam logic [8:0]  NC9          = 9'(NOTE_COUNT);
   localparam logic [15:0] PERFECT_PTS16 = 16'(PERFECT_PTS);
   localparam logic [15:0] GOOD_PTS16    = 16'(GOOD_PTS);

   lane_state_e state_q, state_d;
   logic [7:0]  addr_q, addr_d;
   logic        judgeValid_q, judgeValid_d;
   judge_e      judge_q, judge_d;
   logic [9:0]  combo_q, combo_d;
   logic [15:0] score_q, score_d;
   logic        holding_q, holding_d;

   logic keyPress;
   logic keyRelease;

   key_edge uKeyEdge (
      .clk       (Clk),
      .rst_n     (Reset_n),
      .key_i     (key_in),
      .press_o   (keyPress),
      .release_o (keyRelease)
   );

   note_type_e             headType;
   note_type_e             nextType;
   logic signed [TIME_W:0] dt;
   logic                   inGood;
   logic                   inPerfect;
   judge_e                 graded;
   logic [8:0]             sum1;
   logic [8:0]             sum2;
   logic [7:0]             addrInc1;
   logic [7:0]             addrInc2;
   logic                   unused_key2;

   assign headType    = note_type_e'(key_1[TYPE_HI:TYPE_LO]);
   assign nextType    = note_type_e'(key_2[TYPE_HI:TYPE_LO]);
   assign unused_key2 = ^key_2[TIME_HI:TIME_LO];
   assign dt          = note_dt(song_time, key_1[TIME_HI:TIME_LO]);
   assign inGood      = (dt >= -GOOD_S) && (dt <= GOOD_S);
   assign inPerfect   = (dt >= -PERF_S) && (dt <= PERF_S);
   assign graded      = inPerfect ? J_PERFECT : J_GOOD;

   // The pointer clamps at NOTE_COUNT so a hold start near the end cannot wrap it.
   assign sum1     = {1'b0, addr_q} + 9'd1;
   assign sum2     = {1'b0, addr_q} + 9'd2;
   assign addrInc1 = (sum1 > NC9) ? NC9[7:0] : sum1[7:0];
   assign addrInc2 = (sum2 > NC9) ? NC9[7:0] : sum2[7:0];

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         judgeValid_q <= 1'b0;
         judge_q      <= J_MISS;
         combo_q      <= '0;
         score_q      <= '0;
         holding_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         judgeValid_q <= judgeValid_d;
         judge_q      <= judge_d;
         combo_q      <= combo_d;
         score_q      <= score_d;
         holding_q    <= holding_d;
      end
   end

   always_comb begin
      logic   issue;
      judge_e verdict;

      state_d      = state_q;
      addr_d       = addr_q;
      judgeValid_d = 1'b0;
      judge_d      = judge_q;
      combo_d      = combo_q;
      score_d      = score_q;
      holding_d    = holding_q;
      issue        = 1'b0;
      verdict      = J_MISS;

      case (state_q)
         S_RUN: begin
            if ({1'b0, addr_q} >= NC9) begin
               state_d = S_DONE;
            end else if (dt > GOOD_S) begin
               // An expired hold start also skips its end, so it costs a single miss.
               issue   = 1'b1;
               verdict = J_MISS;
               addr_d  = (headType == NOTE_HOLD_S) ? addrInc2 : addrInc1;
            end else if (keyPress && inGood) begin
               issue   = 1'b1;
               verdict = graded;
               addr_d  = addrInc1;
               if (headType == NOTE_HOLD_S && nextType == NOTE_HOLD_E) begin
                  state_d   = S_HOLD;
                  holding_d = 1'b1;
               end
            end
         end
         S_HOLD: begin
            if (keyRelease || dt >= 0) begin
               issue     = 1'b1;
               verdict   = (keyRelease && !inGood) ? J_MISS :
                           (keyRelease ? graded : J_PERFECT);
               addr_d    = addrInc1;
               holding_d = 1'b0;
               state_d   = S_RUN;
            end
         end
         default: begin
         end
      endcase

      if (issue) begin
         judgeValid_d = 1'b1;
         judge_d      = verdict;
         if (verdict == J_MISS) begin
            combo_d = '0;
         end else begin
            combo_d = (combo_q == 10'h3FF) ? combo_q : combo_q + 10'd1;
            score_d = sat_add16(score_q, (verdict == J_PERFECT) ? PERFECT_PTS16 : GOOD_PTS16);
         end
      end

      if (start) begin
         state_d      = S_RUN;
         addr_d       = '0;
         judgeValid_d = 1'b0;
         combo_d      = '0;
         score_d      = '0;
         holding_d    = 1'b0;
      end
   end

   assign addr        = addr_q;
   assign judge_valid = judgeValid_q;
   assign judge_code  = judge_q;
   assign combo       = combo_q;
   assign score       = score_q;
   assign holding     = holding_q;
   assign done        = (state_q == S_DONE);

endmodule
